// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU encodings, flag bit positions and multiply-sequencer state codes.
package alu_mul_sequencer_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu.sv
// Shared 32-bit ALU: add/sub/and/or with NZCV flags (C is carry-out / no-borrow on sub).
module alu
  import alu_mul_sequencer_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_ctrl,
  output logic [31:0] o_result,
  output logic [3:0]  o_flags
);

  logic [32:0] w_sum;
  logic [31:0] w_b_op;
  logic        w_carry;
  logic        w_ovf;

  assign w_b_op = (i_ctrl == ALU_SUB) ? ~i_b : i_b;
  assign w_sum  = {1'b0, i_a} + {1'b0, w_b_op} + {32'd0, (i_ctrl == ALU_SUB)};

  always_comb begin
    o_result = w_sum[31:0];
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    unique case (i_ctrl)
      ALU_ADD, ALU_SUB: begin
        w_carry = w_sum[32];
        w_ovf   = (i_a[31] == w_b_op[31]) && (w_sum[31] != i_a[31]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      default: o_result = w_sum[31:0];
    endcase
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = o_result[31];
    o_flags[FLAG_Z] = (o_result == 32'd0);
    o_flags[FLAG_C] = w_carry;
    o_flags[FLAG_V] = w_ovf;
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32->64 unsigned multiplier that borrows the shared ALU while running
// and hands it back to the core datapath when idle.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_core_a,
  input  logic [WIDTH-1:0] i_core_b,
  input  logic [1:0]       i_core_ctrl,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [3:0]       i_alu_flags,
  output logic             o_ready,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic [WIDTH-1:0] o_prod_lo
);

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_p_hi, w_p_hi_nxt;
  logic [WIDTH-1:0] r_p_lo, w_p_lo_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_prod_hi, w_prod_hi_nxt;
  logic [WIDTH-1:0] r_prod_lo, w_prod_lo_nxt;

  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic             w_unused_flags;

  // Only the add carry matters; the remaining flags are don't-care here.
  assign w_unused_flags = ^{i_alu_flags[FLAG_V], i_alu_flags[FLAG_Z], i_alu_flags[FLAG_N]};

  // {carry, sum, P_lo} shifted right by one.
  assign w_step_hi = {i_alu_flags[FLAG_C], i_alu_result[WIDTH-1:1]};
  assign w_step_lo = {i_alu_result[0], r_p_lo[WIDTH-1:1]};

  assign o_ready   = (r_state == ST_IDLE);
  assign o_stall   = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_prod_hi = r_prod_hi;
  assign o_prod_lo = r_prod_lo;

  always_comb begin
    o_alu_a    = i_core_a;
    o_alu_b    = i_core_b;
    o_alu_ctrl = i_core_ctrl;
    if (r_state == ST_RUN) begin
      o_alu_a    = r_p_hi;
      o_alu_b    = r_p_lo[0] ? r_mcand : '0;
      o_alu_ctrl = ALU_ADD;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_p_hi_nxt    = r_p_hi;
    w_p_lo_nxt    = r_p_lo;
    w_mcand_nxt   = r_mcand;
    w_prod_hi_nxt = r_prod_hi;
    w_prod_lo_nxt = r_prod_lo;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_mcand_nxt = i_op_a;
          w_p_hi_nxt  = '0;
          w_p_lo_nxt  = i_op_b;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_p_hi_nxt = w_step_hi;
        w_p_lo_nxt = w_step_lo;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt   = ST_DONE;
          w_prod_hi_nxt = w_step_hi;
          w_prod_lo_nxt = w_step_lo;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_mcand   <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p_hi    <= w_p_hi_nxt;
      r_p_lo    <= w_p_lo_nxt;
      r_mcand   <= w_mcand_nxt;
      r_prod_hi <= w_prod_hi_nxt;
      r_prod_lo <= w_prod_lo_nxt;
    end
  end

endmodule
